rob_commit: RTL and testbench

Reorder buffer for the out-of-order RISC-V core: a circular queue of in-flight instructions. It hands a tag (`ROB_Number`) to ISSUE for each allocated instruction and captures ALU results by tag. It retires entries strictly in program order, broadcasting `commit_en` / `commit_Number` / `commit_val` to the reservation station and register file. A mispredicted branch reaching the head raises `clear` and flushes the pipeline.

---
 rtl/rob_commit_if.sv | 35 +++
 rtl/rob_commit.sv | 155 +++++++++++++++
 tb/tb_rob_commit.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/rob_commit_if.sv
// Issue/ALU/commit signal bundle for the reorder buffer.
// The master side drives allocation and results; the slave side is the ROB.
interface rob_commit_if #(
    parameter int unsigned TAG_W = 5
);
    logic             ROB_in;
    logic [4:0]       ROB_dest;
    logic [TAG_W-1:0] ROB_Number;
    logic             ROB_is_full;
    logic             Calc_done;
    logic [TAG_W-1:0] Calc_Number;
    logic [31:0]      Calc_val;
    logic             Calc_mispredict;
    logic [31:0]      Calc_target;
    logic             commit_en;
    logic [TAG_W-1:0] commit_Number;
    logic [31:0]      commit_val;
    logic [4:0]       commit_dest;
    logic             clear;
    logic [31:0]      clear_pc;

    modport master (
        output ROB_in, ROB_dest, Calc_done, Calc_Number, Calc_val,
               Calc_mispredict, Calc_target,
        input  ROB_Number, ROB_is_full, commit_en, commit_Number,
               commit_val, commit_dest, clear, clear_pc
    );

    modport slave (
        input  ROB_in, ROB_dest, Calc_done, Calc_Number, Calc_val,
               Calc_mispredict, Calc_target,
        output ROB_Number, ROB_is_full, commit_en, commit_Number,
               commit_val, commit_dest, clear, clear_pc
    );
endinterface

// File: rtl/rob_commit.sv
// Reorder buffer: circular queue that tags instructions at issue, captures
// results by tag and retires in order, flushing on a mispredicted head.
module rob_commit #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned TAG_W = 5
) (
    input  logic         clk_in,
    input  logic         rst_in,
    input  logic         rdy_in,
    rob_commit_if.slave  bus
);
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    typedef logic [TAG_W-1:0] tag_t;
    localparam tag_t           LAST     = tag_t'(DEPTH - 1);
    localparam logic [TAG_W:0] CNT_FULL = (TAG_W + 1)'(DEPTH);

    logic [DEPTH-1:0] busy_q, busy_d, ready_q, ready_d, misp_q, misp_d;
    logic [4:0]       dest_q   [DEPTH];
    logic [4:0]       dest_d   [DEPTH];
    logic [31:0]      value_q  [DEPTH];
    logic [31:0]      value_d  [DEPTH];
    logic [31:0]      target_q [DEPTH];
    logic [31:0]      target_d [DEPTH];
    tag_t             head_q, head_d, tail_q, tail_d;
    logic [TAG_W:0]   count_q, count_d;
    logic             commit_en_q, commit_en_d, clear_q, clear_d;
    tag_t             commit_num_q, commit_num_d;
    logic [31:0]      commit_val_q, commit_val_d, clear_pc_q, clear_pc_d;
    logic [4:0]       commit_dest_q, commit_dest_d;

    logic             full, alloc, wb, do_commit;
    logic [IDX_W-1:0] h_idx, t_idx, c_idx;

    function automatic tag_t wrap_inc(input tag_t p);
        return (p == LAST) ? '0 : tag_t'(p + 1'b1);
    endfunction

    assign full  = (count_q == CNT_FULL);
    assign h_idx = head_q[IDX_W-1:0];
    assign t_idx = tail_q[IDX_W-1:0];
    assign c_idx = bus.Calc_Number[IDX_W-1:0];

    always_comb begin
        busy_d        = busy_q;
        ready_d       = ready_q;
        misp_d        = misp_q;
        dest_d        = dest_q;
        value_d       = value_q;
        target_d      = target_q;
        head_d        = head_q;
        tail_d        = tail_q;
        count_d       = count_q;
        commit_en_d   = 1'b0;
        clear_d       = 1'b0;
        commit_num_d  = commit_num_q;
        commit_val_d  = commit_val_q;
        commit_dest_d = commit_dest_q;
        clear_pc_d    = clear_pc_q;
        alloc         = 1'b0;
        wb            = 1'b0;
        do_commit     = 1'b0;

        if (rdy_in) begin
            alloc     = bus.ROB_in && !full && !clear_q;
            wb        = bus.Calc_done && !clear_q
                        && ({1'b0, bus.Calc_Number} < CNT_FULL) && busy_q[c_idx];
            do_commit = (count_q != '0) && busy_q[h_idx] && ready_q[h_idx];

            if (wb) begin
                ready_d[c_idx]  = 1'b1;
                value_d[c_idx]  = bus.Calc_val;
                misp_d[c_idx]   = bus.Calc_mispredict;
                target_d[c_idx] = bus.Calc_target;
            end
            if (alloc) begin
                busy_d[t_idx]  = 1'b1;
                ready_d[t_idx] = 1'b0;
                dest_d[t_idx]  = bus.ROB_dest;
                tail_d         = wrap_inc(tail_q);
            end
            if (do_commit) begin
                commit_en_d    = 1'b1;
                commit_num_d   = head_q;
                commit_val_d   = value_q[h_idx];
                commit_dest_d  = dest_q[h_idx];
                busy_d[h_idx]  = 1'b0;
                ready_d[h_idx] = 1'b0;
                head_d         = wrap_inc(head_q);
            end

            unique case ({alloc, do_commit})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase

            // A mispredicted head still retires, then wipes every pointer,
            // discarding any allocation that landed on this same edge.
            if (do_commit && misp_q[h_idx]) begin
                clear_d    = 1'b1;
                clear_pc_d = target_q[h_idx];
                busy_d     = '0;
                ready_d    = '0;
                head_d     = '0;
                tail_d     = '0;
                count_d    = '0;
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            busy_q        <= '0;
            ready_q       <= '0;
            misp_q        <= '0;
            dest_q        <= '{default: '0};
            value_q       <= '{default: '0};
            target_q      <= '{default: '0};
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            commit_en_q   <= 1'b0;
            clear_q       <= 1'b0;
            commit_num_q  <= '0;
            commit_val_q  <= '0;
            commit_dest_q <= '0;
            clear_pc_q    <= '0;
        end else begin
            busy_q        <= busy_d;
            ready_q       <= ready_d;
            misp_q        <= misp_d;
            dest_q        <= dest_d;
            value_q       <= value_d;
            target_q      <= target_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
            commit_en_q   <= commit_en_d;
            clear_q       <= clear_d;
            commit_num_q  <= commit_num_d;
            commit_val_q  <= commit_val_d;
            commit_dest_q <= commit_dest_d;
            clear_pc_q    <= clear_pc_d;
        end
    end

    assign bus.ROB_Number    = tail_q;
    assign bus.ROB_is_full   = full;
    assign bus.commit_en     = commit_en_q;
    assign bus.commit_Number = commit_num_q;
    assign bus.commit_val    = commit_val_q;
    assign bus.commit_dest   = commit_dest_q;
    assign bus.clear         = clear_q;
    assign bus.clear_pc      = clear_pc_q;
endmodule

// File: tb/tb_rob_commit.sv
// Directed bench for rob_commit: vector table for in-order retire and flush,
// hand sequences for full/wrap, stall and asynchronous reset.
module tb_rob_commit;
    logic clk = 1'b0;
    logic rst;
    logic rdy;
    int   total  = 0;
    int   passed = 0;

    rob_commit_if #(.TAG_W(5)) bus();

    rob_commit #(.DEPTH(16), .TAG_W(5)) dut (
        .clk_in (clk),
        .rst_in (rst),
        .rdy_in (rdy),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ri;
        logic [4:0]  dest;
        logic        cd;
        logic [4:0]  cn;
        logic [31:0] cv;
        logic        cm;
        logic [31:0] ct;
        logic [4:0]  e_tag;
        logic        e_cen;
        logic [4:0]  e_cnum;
        logic [31:0] e_cval;
        logic [4:0]  e_cdest;
        logic        e_clr;
        logic [31:0] e_clrpc;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(input logic ri, input logic [4:0] d,
                               input logic cd, input logic [4:0] cn,
                               input logic [31:0] cv, input logic cm,
                               input logic [31:0] ct, input logic [4:0] et,
                               input logic cen, input logic [4:0] cnum,
                               input logic [31:0] cval, input logic [4:0] cdest,
                               input logic clr, input logic [31:0] cpc);
        vec_t r;
        r.ri = ri; r.dest = d; r.cd = cd; r.cn = cn; r.cv = cv; r.cm = cm;
        r.ct = ct; r.e_tag = et; r.e_cen = cen; r.e_cnum = cnum;
        r.e_cval = cval; r.e_cdest = cdest; r.e_clr = clr; r.e_clrpc = cpc;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.ROB_in = 1'b0; bus.ROB_dest = '0; bus.Calc_done = 1'b0;
        bus.Calc_Number = '0; bus.Calc_val = '0; bus.Calc_mispredict = 1'b0;
        bus.Calc_target = '0;
    endtask

    task automatic wb(input logic [4:0] tag, input logic [31:0] val);
        bus.Calc_done = 1'b1; bus.Calc_Number = tag; bus.Calc_val = val;
        bus.Calc_mispredict = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; rdy = 1'b1;
        idle_inputs();
        #12;
        chk("rst_commit_en", 32'(bus.commit_en), 0);
        chk("rst_clear", 32'(bus.clear), 0);
        chk("rst_tag", 32'(bus.ROB_Number), 0);
        chk("rst_full", 32'(bus.ROB_is_full), 0);
        rst = 1'b0;
        tick();

        // single instruction
        vecs.push_back(v(1,5, 0,0,0,0,0,            0, 0,0,0,0, 0,0));
        vecs.push_back(v(0,0, 1,0,32'h1234,0,0,     1, 0,0,0,0, 0,0));
        vecs.push_back(v(0,0, 0,0,0,0,0,            1, 1,0,32'h1234,5, 0,0));
        vecs.push_back(v(0,0, 0,0,0,0,0,            1, 0,0,0,0, 0,0));
        // out-of-order results, in-order retire
        vecs.push_back(v(1,1, 0,0,0,0,0,            1, 0,0,0,0, 0,0));
        vecs.push_back(v(1,2, 0,0,0,0,0,            2, 0,0,0,0, 0,0));
        vecs.push_back(v(1,3, 0,0,0,0,0,            3, 0,0,0,0, 0,0));
        vecs.push_back(v(0,0, 1,3,32'h33,0,0,       4, 0,0,0,0, 0,0));
        vecs.push_back(v(0,0, 1,1,32'h11,0,0,       4, 0,0,0,0, 0,0));
        vecs.push_back(v(0,0, 1,2,32'h22,0,0,       4, 1,1,32'h11,1, 0,0));
        vecs.push_back(v(0,0, 0,0,0,0,0,            4, 1,2,32'h22,2, 0,0));
        vecs.push_back(v(0,0, 0,0,0,0,0,            4, 1,3,32'h33,3, 0,0));
        vecs.push_back(v(0,0, 0,0,0,0,0,            4, 0,0,0,0, 0,0));
        // mispredict flush
        vecs.push_back(v(1,4, 0,0,0,0,0,            4, 0,0,0,0, 0,0));
        vecs.push_back(v(1,6, 0,0,0,0,0,            5, 0,0,0,0, 0,0));
        vecs.push_back(v(1,7, 0,0,0,0,0,            6, 0,0,0,0, 0,0));
        vecs.push_back(v(1,8, 0,0,0,0,0,            7, 0,0,0,0, 0,0));
        vecs.push_back(v(0,0, 1,4,32'h44,1,32'h80,  8, 0,0,0,0, 0,0));
        vecs.push_back(v(1,9, 0,0,0,0,0,            8, 1,4,32'h44,4, 1,32'h80));
        vecs.push_back(v(1,9, 1,5,32'h55,0,0,       0, 0,0,0,0, 0,0));
        vecs.push_back(v(0,0, 1,6,32'h66,0,0,       0, 0,0,0,0, 0,0));
        vecs.push_back(v(1,10,1,7,32'h77,0,0,       0, 0,0,0,0, 0,0));
        vecs.push_back(v(0,0, 1,0,32'hAA,0,0,       1, 0,0,0,0, 0,0));
        vecs.push_back(v(0,0, 0,0,0,0,0,            1, 1,0,32'hAA,10, 0,0));
        vecs.push_back(v(0,0, 0,0,0,0,0,            1, 0,0,0,0, 0,0));

        foreach (vecs[k]) begin
            bus.ROB_in = vecs[k].ri; bus.ROB_dest = vecs[k].dest;
            bus.Calc_done = vecs[k].cd; bus.Calc_Number = vecs[k].cn;
            bus.Calc_val = vecs[k].cv; bus.Calc_mispredict = vecs[k].cm;
            bus.Calc_target = vecs[k].ct;
            #1;
            chk($sformatf("v%0d_tag", k), 32'(bus.ROB_Number), 32'(vecs[k].e_tag));
            chk($sformatf("v%0d_full", k), 32'(bus.ROB_is_full), 0);
            tick();
            chk($sformatf("v%0d_commit_en", k), 32'(bus.commit_en), 32'(vecs[k].e_cen));
            if (vecs[k].e_cen) begin
                chk($sformatf("v%0d_commit_num", k), 32'(bus.commit_Number), 32'(vecs[k].e_cnum));
                chk($sformatf("v%0d_commit_val", k), bus.commit_val, vecs[k].e_cval);
                chk($sformatf("v%0d_commit_dest", k), 32'(bus.commit_dest), 32'(vecs[k].e_cdest));
            end
            chk($sformatf("v%0d_clear", k), 32'(bus.clear), 32'(vecs[k].e_clr));
            if (vecs[k].e_clr)
                chk($sformatf("v%0d_clear_pc", k), bus.clear_pc, vecs[k].e_clrpc);
        end
        idle_inputs();

        // async reset clears held commit/flush outputs
        #2 rst = 1'b1;
        #1;
        chk("arst_commit_val", bus.commit_val, 0);
        chk("arst_commit_dest", 32'(bus.commit_dest), 0);
        chk("arst_clear_pc", bus.clear_pc, 0);
        rst = 1'b0;
        tick();

        // full and wrap
        for (int i = 0; i < 16; i++) begin
            bus.ROB_in = 1'b1; bus.ROB_dest = 5'(i);
            #1;
            chk($sformatf("fill_tag%0d", i), 32'(bus.ROB_Number), 32'(i));
            tick();
        end
        chk("full_set", 32'(bus.ROB_is_full), 1);
        chk("full_tag_wrap", 32'(bus.ROB_Number), 0);
        tick();
        chk("full_17th_ignored_tag", 32'(bus.ROB_Number), 0);
        chk("full_17th_still_full", 32'(bus.ROB_is_full), 1);
        wb(5'd0, 32'h77);
        tick();
        chk("full_wb_no_commit", 32'(bus.commit_en), 0);
        bus.Calc_done = 1'b0;
        tick();
        chk("full_commit_en", 32'(bus.commit_en), 1);
        chk("full_commit_num", 32'(bus.commit_Number), 0);
        chk("full_commit_val", bus.commit_val, 32'h77);
        chk("full_alloc_refused", 32'(bus.ROB_is_full), 0);
        chk("full_refused_tag", 32'(bus.ROB_Number), 0);
        tick();
        chk("wrap_alloc_full", 32'(bus.ROB_is_full), 1);
        chk("wrap_alloc_tag", 32'(bus.ROB_Number), 1);
        bus.ROB_in = 1'b0;

        // stall with a ready head
        wb(5'd1, 32'h99);
        tick();
        rdy = 1'b0; bus.Calc_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("stall%0d_commit_en", i), 32'(bus.commit_en), 0);
            chk($sformatf("stall%0d_full", i), 32'(bus.ROB_is_full), 1);
        end
        rdy = 1'b1;
        tick();
        chk("unstall_commit_en", 32'(bus.commit_en), 1);
        chk("unstall_commit_num", 32'(bus.commit_Number), 1);
        chk("unstall_commit_val", bus.commit_val, 32'h99);
        chk("unstall_commit_dest", 32'(bus.commit_dest), 1);
        chk("unstall_full", 32'(bus.ROB_is_full), 0);

        // reset mid-cycle with a pending commit
        wb(5'd2, 32'h5A);
        tick();
        bus.Calc_done = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("mrst_commit_en", 32'(bus.commit_en), 0);
        chk("mrst_commit_num", 32'(bus.commit_Number), 0);
        chk("mrst_commit_val", bus.commit_val, 0);
        chk("mrst_commit_dest", 32'(bus.commit_dest), 0);
        chk("mrst_clear", 32'(bus.clear), 0);
        chk("mrst_clear_pc", bus.clear_pc, 0);
        chk("mrst_tag", 32'(bus.ROB_Number), 0);
        chk("mrst_full", 32'(bus.ROB_is_full), 0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk("post_rst_no_pulse0", 32'(bus.commit_en), 0);
        tick();
        chk("post_rst_no_pulse1", 32'(bus.commit_en), 0);
        chk("post_rst_tag", 32'(bus.ROB_Number), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
